// File: rtl/fetch_stage_pkg.sv
// Shared RV32I fetch definitions: widths, the canonical NOP and the buffer entry layout.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One decoded-side buffer slot: the instruction word and the PC it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instruction fetches are always word aligned; low address bits are discarded.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage boundary: imem request/response, EX redirect and the decode handshake.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;

  // The fetch stage itself.
  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );

  // Surroundings: instruction memory, EX and decode.
  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_stage_fifo.sv
// Small synchronous FIFO with flush; used for the in-flight PC queue and the instruction buffer.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot the same cycle, so a full FIFO may still accept a push.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; flush discards all contents.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; stale data behind the pointers is never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // The owner's credit scheme must never push into a full FIFO without a pop.
  assert property (@(posedge clk) disable iff (reset || flush) !(push && full && !pop));

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the fetch PC, issues credit-limited imem requests, buffers
// responses with their PCs for decode, and drops stale responses after a redirect.
module fetch_stage import fetch_stage_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic           clk,
  input  logic           reset,
  fetch_stage_if.master  bus
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   buf_count;
  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            buf_push;
  logic            buf_pop;
  logic            buf_empty;
  logic            buf_full;
  logic            pcq_empty;
  logic            pcq_full;
  logic [XLEN-1:0] pcq_head;
  fetch_entry_t    rsp_entry;
  fetch_entry_t    buf_head;
  logic            unused_ok;

  assign unused_ok = &{1'b0, buf_full, pcq_full, pcq_empty};

  // Issue: a request may go out only while every outstanding fetch has a guaranteed buffer slot.
  assign credit_used        = {1'b0, inflight} + {1'b0, buf_count};
  assign bus.imem_req_valid = !reset && !bus.redirect_valid &&
                              (credit_used < (CW+1)'(BUF_DEPTH));
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  // Response: kept only when no stale responses remain to be discarded.
  assign rsp_entry = '{pc: pcq_head, instr: bus.imem_rsp_data};
  assign buf_push  = bus.imem_rsp_valid && (drop_cnt == '0);
  assign buf_pop   = bus.id_ready && !buf_empty;

  assign bus.id_valid = !buf_empty;
  assign bus.id_instr = buf_empty ? NOP_INSTR : buf_head.instr;
  assign bus.id_pc    = buf_empty ? '0 : buf_head.pc;

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (BUF_DEPTH)
  ) u_pc_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (bus.imem_rsp_valid),
    .head      (pcq_head),
    .count     (inflight),
    .full      (pcq_full),
    .empty     (pcq_empty)
  );

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (BUF_DEPTH)
  ) u_instr_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.redirect_valid),
    .push      (buf_push),
    .push_data (rsp_entry),
    .pop       (buf_pop),
    .head      (buf_head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  // Fetch PC: redirect target wins, otherwise advance by one word per accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      fetch_pc <= align_word(bus.redirect_pc);
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Stale-response counter. The PC queue tracks every outstanding request,
  // stale or not, so after a redirect everything still outstanding is stale;
  // counting it this way keeps back-to-back redirects from over-dropping.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (bus.redirect_valid) begin
      drop_cnt <= inflight + CW'(req_fire) - CW'(bus.imem_rsp_valid);
    end else if (bus.imem_rsp_valid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a word-stream reference model (expected
// next request PC, expected next decode PC, live-instruction count per redirect
// generation) checks every cycle, with directed sequences and a randomized phase.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] SALT   = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    int unsigned gen;
  } req_t;

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] a0;
    logic [31:0] a1;
  } vec_t;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  int unsigned gen   = 0;
  int unsigned buffered = 0;
  int unsigned lat   = 1;
  int unsigned p_rdy = 100;
  int unsigned p_idr = 100;
  logic        rst_in   = 1'b1;
  logic        prev_rst = 1'b0;
  logic        do_redir = 1'b0;
  logic [31:0] redir_tgt = '0;
  logic [31:0] exp_req = RST_PC;
  logic [31:0] exp_id  = RST_PC;
  req_t        imq[$];
  logic [31:0] acc_log[$];
  logic [31:0] id_log[$];
  logic [31:0] id_cyc[$];
  vec_t        vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%b required=%b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic clear_logs();
    acc_log.delete();
    id_log.delete();
    id_cyc.delete();
  endtask

  // One clock: drive imem/EX/decode, check outputs mid-cycle, then advance the model.
  task automatic cycle();
    logic        rsp_v;
    logic [31:0] rsp_d;
    int unsigned rsp_gen;
    logic        acc;
    logic        cons;
    logic        exp_rv;
    logic [31:0] acc_addr;
    logic [31:0] pc_s;
    int unsigned outst;
    if (!rst_in && prev_rst) imq.delete();
    rsp_v = 1'b0;
    rsp_d = '0;
    rsp_gen = 0;
    if (imq.size() > 0 && imq[0].due <= cyc) begin
      rsp_v   = 1'b1;
      rsp_d   = imq[0].addr ^ SALT;
      rsp_gen = imq[0].gen;
      imq.delete(0);
    end
    reset              = rst_in;
    bus.imem_rsp_valid = rsp_v;
    bus.imem_rsp_data  = rsp_d;
    bus.imem_req_ready = ($urandom_range(99) < p_rdy);
    bus.id_ready       = ($urandom_range(99) < p_idr);
    bus.redirect_valid = do_redir;
    bus.redirect_pc    = redir_tgt;
    #4;
    outst  = imq.size() + (rsp_v ? 1 : 0);
    exp_rv = !rst_in && !do_redir && (outst + buffered < 2);
    chk1("req_valid", bus.imem_req_valid, exp_rv);
    acc      = bus.imem_req_valid && bus.imem_req_ready;
    acc_addr = bus.imem_req_addr;
    pc_s     = bus.id_pc;
    if (acc) chk("req_addr", acc_addr, exp_req);
    cons = 1'b0;
    if (!rst_in) begin
      chk1("id_valid", bus.id_valid, buffered != 0);
      if (buffered != 0) begin
        chk("id_pc", bus.id_pc, exp_id);
        chk("id_instr", bus.id_instr, exp_id ^ SALT);
      end else begin
        chk("idle_instr", bus.id_instr, NOP);
        chk("idle_pc", bus.id_pc, 32'h0);
      end
      cons = bus.id_valid && bus.id_ready && !do_redir;
    end else if (prev_rst) begin
      chk1("rst_id_valid", bus.id_valid, 1'b0);
      chk("rst_id_instr", bus.id_instr, NOP);
      chk("rst_id_pc", bus.id_pc, 32'h0);
    end
    @(posedge clk);
    #1;
    if (rst_in) begin
      buffered = 0;
      gen++;
      exp_req = RST_PC;
      exp_id  = RST_PC;
    end else begin
      if (acc) begin
        imq.push_back('{addr: acc_addr, due: cyc + lat, gen: gen});
        exp_req = exp_req + 32'd4;
        acc_log.push_back(acc_addr);
      end
      if (rsp_v && rsp_gen == gen) buffered++;
      if (cons && buffered != 0) begin
        buffered--;
        id_log.push_back(pc_s);
        id_cyc.push_back(cyc);
        exp_id = exp_id + 32'd4;
      end
      if (do_redir) begin
        buffered = 0;
        gen++;
        exp_req = {redir_tgt[31:2], 2'b00};
        exp_id  = {redir_tgt[31:2], 2'b00};
      end
    end
    prev_rst = rst_in;
    do_redir = 1'b0;
    cyc++;
  endtask

  task automatic do_reset(input int unsigned n);
    rst_in = 1'b1;
    repeat (n) cycle();
    rst_in = 1'b0;
  endtask

  // Bounded wait until both logs hold at least n entries.
  task automatic wait_logs(input string name, input int n);
    int unsigned k = 0;
    while ((acc_log.size() < n || id_log.size() < n) && k < 60) begin
      cycle();
      k++;
    end
    chk1(name, k < 60, 1'b1);
  endtask

  initial begin
    int unsigned c0;
    int unsigned k;
    int unsigned delivered;

    vecs[0] = '{tgt: 32'h0000_0103, a0: 32'h0000_0100, a1: 32'h0000_0104};
    vecs[1] = '{tgt: 32'hFFFF_FFFC, a0: 32'hFFFF_FFFC, a1: 32'h0000_0000};
    vecs[2] = '{tgt: 32'h0000_0002, a0: 32'h0000_0000, a1: 32'h0000_0004};
    vecs[3] = '{tgt: 32'h1000_0001, a0: 32'h1000_0000, a1: 32'h1000_0004};
    vecs[4] = '{tgt: 32'h7FFF_FFFF, a0: 32'h7FFF_FFFC, a1: 32'h8000_0000};

    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b0;
    reset              = 1'b1;

    // Sequential fetch with a 1-cycle imem and decode always ready.
    lat = 1; p_rdy = 100; p_idr = 100;
    do_reset(3);
    clear_logs();
    c0 = cyc;
    repeat (12) cycle();
    chk("t1_req0", qget(acc_log, 0), 32'h0);
    chk("t1_req1", qget(acc_log, 1), 32'h4);
    chk("t1_req2", qget(acc_log, 2), 32'h8);
    chk("t1_id0", qget(id_log, 0), 32'h0);
    chk("t1_id1", qget(id_log, 1), 32'h4);
    chk("t1_id2", qget(id_log, 2), 32'h8);
    chk("t1_first_valid", qget(id_cyc, 0) - c0, 32'd2);

    // Decode stalled: credits stop issue after two requests.
    p_idr = 0;
    do_reset(2);
    clear_logs();
    repeat (10) cycle();
    chk("t2_req_count", 32'(acc_log.size()), 32'd2);
    chk("t2_req0", qget(acc_log, 0), 32'h0);
    chk("t2_req1", qget(acc_log, 1), 32'h4);
    p_idr = 100;
    wait_logs("t2_wait", 3);
    chk("t2_id0", qget(id_log, 0), 32'h0);
    chk("t2_id1", qget(id_log, 1), 32'h4);
    chk("t2_id2", qget(id_log, 2), 32'h8);

    // 3-cycle imem, two stale requests outstanding at the redirect.
    lat = 3;
    do_reset(2);
    k = 0;
    while (imq.size() < 2 && k < 20) begin
      cycle();
      k++;
    end
    chk1("t3_two_inflight", imq.size() == 2, 1'b1);
    clear_logs();
    do_redir = 1'b1;
    redir_tgt = 32'h0000_0100;
    cycle();
    wait_logs("t3_wait", 1);
    chk("t3_req", qget(acc_log, 0), 32'h100);
    chk("t3_id", qget(id_log, 0), 32'h100);

    // Redirect coinciding with a response while another request is still outstanding.
    lat = 2;
    do_reset(2);
    repeat (2) cycle();
    clear_logs();
    do_redir = 1'b1;
    redir_tgt = 32'h0000_0040;
    cycle();
    wait_logs("t4_wait", 2);
    chk("t4_req", qget(acc_log, 0), 32'h40);
    chk("t4_id0", qget(id_log, 0), 32'h40);
    chk("t4_id1", qget(id_log, 1), 32'h44);

    // Redirect target alignment and address wrap.
    lat = 1; p_rdy = 100; p_idr = 100;
    do_reset(2);
    repeat (4) cycle();
    for (int i = 0; i < 5; i++) begin
      clear_logs();
      do_redir = 1'b1;
      redir_tgt = vecs[i].tgt;
      cycle();
      wait_logs("t5_wait", 2);
      chk("t5_req0", qget(acc_log, 0), vecs[i].a0);
      chk("t5_req1", qget(acc_log, 1), vecs[i].a1);
      chk("t5_id0", qget(id_log, 0), vecs[i].a0);
      chk("t5_id1", qget(id_log, 1), vecs[i].a1);
    end

    // Reset with one buffered instruction and one response arriving during reset.
    lat = 3; p_idr = 0;
    do_reset(2);
    repeat (4) cycle();
    chk1("t6_setup", (buffered == 1) && (imq.size() == 1), 1'b1);
    do_reset(2);
    clear_logs();
    p_idr = 100;
    wait_logs("t6_wait", 1);
    chk("t6_req", qget(acc_log, 0), RST_PC);
    chk("t6_id", qget(id_log, 0), RST_PC);

    // Randomized traffic: latency, ready probabilities, redirects and resets.
    clear_logs();
    for (int s = 0; s < 12; s++) begin
      lat   = $urandom_range(4, 1);
      p_rdy = $urandom_range(100, 30);
      p_idr = $urandom_range(100, 20);
      for (int n = 0; n < 250; n++) begin
        if ($urandom_range(199) == 0) begin
          do_reset($urandom_range(2, 1));
        end else begin
          do_redir  = ($urandom_range(99) < 4);
          redir_tgt = $urandom();
          cycle();
        end
      end
    end
    delivered = id_log.size();
    chk1("rand_progress", delivered > 200, 1'b1);

    // Drain: with decode ready and no redirects everything outstanding must clear.
    p_idr = 100; p_rdy = 0;
    repeat (20) cycle();
    chk1("drain_empty", (buffered == 0) && (imq.size() == 0), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
